// File: rtl/sad_operand_loader.sv
// Byte-stream loader for the SAD_128 operand SRAMs: even bytes go to memory A,
// odd bytes to memory B, then Go is pulsed and the loader waits for Sad_Done.
module sad_operand_loader #(
  parameter int A_WIDTH = 15,
  parameter int D_WIDTH = 8,
  parameter int WORDS   = 32768
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Load,
  input  logic [D_WIDTH-1:0] In_Data,
  input  logic               In_Valid,
  output logic               In_Ready,
  output logic [A_WIDTH-1:0] A_Addr,
  output logic [D_WIDTH-1:0] A_Di,
  output logic [A_WIDTH-1:0] B_Addr,
  output logic [D_WIDTH-1:0] B_Di,
  output logic               I_RW,
  output logic               I_En,
  output logic               Go,
  input  logic               Sad_Done,
  output logic               Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV_A = 3'd1,
    RECV_B = 3'd2,
    WRITE  = 3'd3,
    START  = 3'd4,
    WAIT   = 3'd5
  } state_t;

  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(WORDS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [A_WIDTH-1:0] cnt;
  logic [D_WIDTH-1:0] a_reg;
  logic               hs;

  assign hs = In_Valid & In_Ready;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Load) state_nxt = RECV_A;
      RECV_A:  if (hs) state_nxt = RECV_B;
      RECV_B:  if (hs) state_nxt = WRITE;
      WRITE:   state_nxt = (cnt == LAST_ADDR) ? START : RECV_A;
      START:   state_nxt = WAIT;
      WAIT:    if (Sad_Done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    In_Ready = 1'b0;
    I_En     = 1'b0;
    I_RW     = 1'b0;
    Go       = 1'b0;
    Busy     = 1'b0;
    case (state)
      RECV_A, RECV_B: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
      end
      WRITE: begin
        I_En = 1'b1;
        I_RW = 1'b1;
        Busy = 1'b1;
      end
      START: begin
        Go   = 1'b1;
        Busy = 1'b1;
      end
      WAIT:    Busy = 1'b1;
      default: ;
    endcase
  end

  // Address/data outputs are loaded on the B handshake so they are already
  // valid during WRITE and then hold until the next pair.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt    <= '0;
      a_reg  <= '0;
      A_Addr <= '0;
      B_Addr <= '0;
      A_Di   <= '0;
      B_Di   <= '0;
    end else begin
      case (state)
        IDLE:   if (Load) cnt <= '0;
        RECV_A: if (hs) a_reg <= In_Data;
        RECV_B: if (hs) begin
          A_Addr <= cnt;
          B_Addr <= cnt;
          A_Di   <= a_reg;
          B_Di   <= In_Data;
        end
        WRITE:  if (cnt != LAST_ADDR) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_operand_loader.sv
// Directed bench for sad_operand_loader: WORDS=4 main instance plus a
// 2-bit-address instance where WORDS fills the whole address space.
module tb_sad_operand_loader;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst, Load, In_Valid, Sad_Done;
  logic [DW-1:0] In_Data;
  logic          In_Ready, I_RW, I_En, Go, Busy;
  logic [AW-1:0] A_Addr, B_Addr;
  logic [DW-1:0] A_Di, B_Di;
  logic          d2_In_Ready, d2_I_RW, d2_I_En, d2_Go, d2_Busy;
  logic [1:0]    d2_A_Addr, d2_B_Addr;
  logic [DW-1:0] d2_A_Di, d2_B_Di;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  sad_operand_loader #(.A_WIDTH(AW), .D_WIDTH(DW), .WORDS(4)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .A_Addr(A_Addr), .A_Di(A_Di), .B_Addr(B_Addr), .B_Di(B_Di),
    .I_RW(I_RW), .I_En(I_En), .Go(Go), .Sad_Done(Sad_Done), .Busy(Busy));

  sad_operand_loader #(.A_WIDTH(2), .D_WIDTH(DW), .WORDS(4)) dut2 (
    .Clk(Clk), .Rst(Rst), .Load(Load), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(d2_In_Ready), .A_Addr(d2_A_Addr), .A_Di(d2_A_Di), .B_Addr(d2_B_Addr),
    .B_Di(d2_B_Di), .I_RW(d2_I_RW), .I_En(d2_I_En), .Go(d2_Go), .Sad_Done(Sad_Done),
    .Busy(d2_Busy));

  // Write/Go log collected mid-cycle
  int            cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [AW-1:0] wr_baddr[$];
  logic [DW-1:0] wr_a[$];
  logic [DW-1:0] wr_b[$];
  int            go_n, go_cyc, hs_first, d2_wr_n;
  logic [1:0]    d2_last;

  const logic [DW-1:0] EXP_A[4] = '{8'h11, 8'h33, 8'h55, 8'h77};
  const logic [DW-1:0] EXP_B[4] = '{8'h22, 8'h44, 8'h66, 8'h88};

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (I_En && I_RW) begin
      wr_addr.push_back(A_Addr);
      wr_baddr.push_back(B_Addr);
      wr_a.push_back(A_Di);
      wr_b.push_back(B_Di);
    end
    if (Go) begin
      go_n++;
      go_cyc = cyc;
    end
    if (In_Valid && In_Ready && hs_first < 0) hs_first = cyc;
    if (d2_I_En && d2_I_RW) begin
      d2_wr_n++;
      d2_last = d2_A_Addr;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_baddr.delete();
    wr_a.delete();
    wr_b.delete();
    go_n = 0;
    go_cyc = 0;
    hs_first = -1;
    d2_wr_n = 0;
    d2_last = '0;
  endtask

  // Drives Load then the 8-byte stream 0x11..0x88. vmode=1 toggles In_Valid
  // 1,0,0,1; load_in_b raises Load while in RECV_B; done_at raises Sad_Done
  // while that many bytes have been consumed; stop_writes aborts after N writes.
  task automatic stream(input int vmode, input bit load_in_b, input int done_at,
                        input int stop_writes, output int consumed, output int ready_drops);
    int  k = 0;
    int  t = 0;
    bit  hs;
    ready_drops = 0;
    Load = 1'b1;
    step();
    Load = 1'b0;
    while (k < 8 && t < 200) begin
      if (stop_writes > 0 && wr_a.size() >= stop_writes) break;
      In_Valid = (vmode == 0) ? 1'b1 : ((t % 4) == 0 || (t % 4) == 3);
      In_Data  = 8'(8'h11 * (k + 1));
      Load     = load_in_b && (k % 2 == 1);
      Sad_Done = (k == done_at);
      if (!In_Valid && (k % 2 == 1) && !In_Ready) ready_drops++;
      hs = In_Valid && In_Ready;
      step();
      t++;
      if (hs) k++;
    end
    In_Valid = 1'b0;
    Load     = 1'b0;
    Sad_Done = 1'b0;
    consumed = k;
  endtask

  task automatic wait_go();
    for (int i = 0; i < 10 && go_n == 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    Rst = 1'b1; Load = 1'b0; In_Valid = 1'b0; In_Data = '0; Sad_Done = 1'b0;
    step(); step();
    Rst = 1'b0;
    checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", In_Ready); end
    checks++; if ({I_En, I_RW, Go, Busy} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {I_En, I_RW, Go, Busy}); end
    checks++; if (A_Addr !== '0 || B_Addr !== '0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", A_Addr, B_Addr); end
    checks++; if (A_Di !== '0 || B_Di !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", A_Di, B_Di); end
  endtask

  task automatic test_basic_load();
    int k, rd;
    clear_log();
    stream(0, 1'b0, -1, 0, k, rd);
    checks++; if (k !== 8) begin errors++; $display("FAIL basic_consumed got %0d want 8", k); end
    wait_go();
    checks++; if (wr_a.size() !== 4) begin errors++; $display("FAIL basic_nwrites got %0d want 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_baddr[i] !== AW'(i) || wr_a[i] !== EXP_A[i] || wr_b[i] !== EXP_B[i]) begin
        errors++;
        $display("FAIL basic_write%0d got addr %h/%h data %h/%h want %h %h/%h", i, wr_addr[i], wr_baddr[i], wr_a[i], wr_b[i], i, EXP_A[i], EXP_B[i]);
      end
    end
    checks++; if (go_n !== 1) begin errors++; $display("FAIL basic_go_count got %0d want 1", go_n); end
    checks++; if (go_cyc - hs_first !== 12) begin errors++; $display("FAIL basic_go_latency got %0d want 12", go_cyc - hs_first); end
    step(); step();
    checks++; if (Busy !== 1'b1 || In_Ready !== 1'b0 || I_En !== 1'b0) begin errors++; $display("FAIL basic_wait got busy %b rdy %b en %b want 1 0 0", Busy, In_Ready, I_En); end
    checks++; if (A_Addr !== AW'(3) || A_Di !== 8'h77 || B_Di !== 8'h88) begin errors++; $display("FAIL basic_hold got %h %h %h want 3 77 88", A_Addr, A_Di, B_Di); end
    checks++; if (d2_wr_n !== 4 || d2_last !== 2'b11) begin errors++; $display("FAIL full_space got %0d writes last %b want 4 11", d2_wr_n, d2_last); end
    Sad_Done = 1'b1;
    step();
    Sad_Done = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got %b want 0", Busy); end
  endtask

  task automatic test_valid_toggle();
    int k, rd;
    clear_log();
    stream(1, 1'b0, -1, 0, k, rd);
    wait_go();
    checks++; if (rd !== 0) begin errors++; $display("FAIL toggle_ready_drops got %0d want 0", rd); end
    checks++; if (wr_a.size() !== 4) begin errors++; $display("FAIL toggle_nwrites got %0d want 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_a[i] !== EXP_A[i] || wr_b[i] !== EXP_B[i]) begin
        errors++;
        $display("FAIL toggle_write%0d got %h %h/%h want %h %h/%h", i, wr_addr[i], wr_a[i], wr_b[i], i, EXP_A[i], EXP_B[i]);
      end
    end
    checks++; if (go_n !== 1) begin errors++; $display("FAIL toggle_go_count got %0d want 1", go_n); end
    Sad_Done = 1'b1; step(); Sad_Done = 1'b0;
  endtask

  task automatic test_load_ignored();
    int k, rd;
    clear_log();
    stream(0, 1'b1, -1, 0, k, rd);
    wait_go();
    checks++; if (wr_a.size() !== 4) begin errors++; $display("FAIL ldig_nwrites got %0d want 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_a[i] !== EXP_A[i] || wr_b[i] !== EXP_B[i]) begin
        errors++;
        $display("FAIL ldig_write%0d got %h %h/%h want %h %h/%h", i, wr_addr[i], wr_a[i], wr_b[i], i, EXP_A[i], EXP_B[i]);
      end
    end
    Load = 1'b1; step(); step(); Load = 1'b0;
    checks++; if (Busy !== 1'b1 || In_Ready !== 1'b0 || go_n !== 1) begin errors++; $display("FAIL ldig_wait got busy %b rdy %b go %0d want 1 0 1", Busy, In_Ready, go_n); end
    Load = 1'b1; Sad_Done = 1'b1;
    step();
    Load = 1'b0; Sad_Done = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ldig_done_busy got %b want 0", Busy); end
    step();
    checks++; if (Busy !== 1'b0 || In_Ready !== 1'b0) begin errors++; $display("FAIL ldig_idle got busy %b rdy %b want 0 0", Busy, In_Ready); end
  endtask

  task automatic test_reset_midrun();
    int k, rd;
    clear_log();
    stream(0, 1'b0, -1, 2, k, rd);
    checks++; if (wr_a.size() !== 2) begin errors++; $display("FAIL rst_pre_writes got %0d want 2", wr_a.size()); end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++; if ({In_Ready, I_En, I_RW, Go, Busy} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b want 00000", {In_Ready, I_En, I_RW, Go, Busy}); end
    checks++; if (A_Addr !== '0 || B_Addr !== '0 || A_Di !== '0 || B_Di !== '0) begin errors++; $display("FAIL rst_dp got %h %h %h %h want 0", A_Addr, B_Addr, A_Di, B_Di); end
    repeat (5) step();
    checks++; if (go_n !== 0 || Busy !== 1'b0) begin errors++; $display("FAIL rst_no_go got go %0d busy %b want 0 0", go_n, Busy); end
    clear_log();
    stream(0, 1'b0, -1, 0, k, rd);
    wait_go();
    checks++; if (wr_a.size() !== 4) begin errors++; $display("FAIL rst_reload_n got %0d want 4", wr_a.size()); end
    if (wr_a.size() > 0) begin
      checks++;
      if (wr_addr[0] !== '0 || wr_a[0] !== 8'h11 || wr_b[0] !== 8'h22) begin
        errors++;
        $display("FAIL rst_reload_first got %h %h/%h want 0 11/22", wr_addr[0], wr_a[0], wr_b[0]);
      end
    end
    checks++; if (go_n !== 1) begin errors++; $display("FAIL rst_reload_go got %0d want 1", go_n); end
    Sad_Done = 1'b1; step(); Sad_Done = 1'b0;
  endtask

  task automatic test_done_ignored();
    int k, rd;
    clear_log();
    stream(0, 1'b0, 2, 0, k, rd);
    wait_go();
    checks++; if (k !== 8 || wr_a.size() !== 4) begin errors++; $display("FAIL dnig_progress got %0d bytes %0d writes want 8 4", k, wr_a.size()); end
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_a[i] !== EXP_A[i] || wr_b[i] !== EXP_B[i]) begin
        errors++;
        $display("FAIL dnig_write%0d got %h %h/%h want %h %h/%h", i, wr_addr[i], wr_a[i], wr_b[i], i, EXP_A[i], EXP_B[i]);
      end
    end
    checks++; if (go_n !== 1 || Busy !== 1'b1) begin errors++; $display("FAIL dnig_go got go %0d busy %b want 1 1", go_n, Busy); end
    Sad_Done = 1'b1; step(); Sad_Done = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dnig_done_busy got %b want 0", Busy); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_load_ignored();
    test_reset_midrun();
    test_done_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
